// File: rtl/mem_arb_pkg.sv
// Shared types and reset constants for mem_port_arbiter.
// The optional stall statistics are enabled by defining MEM_ARB_STATS_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

  localparam arb_state_t STATE_RST      = IDLE;
  localparam grant_t     LAST_GRANT_RST = GRANT_IF;
  localparam logic       FLAG_RST       = 1'b0;
  localparam int         STAT_W         = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else if (i_clr) begin
      count_q <= '0;
    end else if (i_inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between fetch and the MEM stage.
// Defining MEM_ARB_STATS_EN adds saturating stall-cycle counters and i_stats_clr.
//
// Handshakes: o_port_valid is held with stable fields until i_port_ready is seen
// high in the same cycle; exactly one i_port_rvalid is then awaited. Requesters
// hold i_*_req until their one-cycle o_*_done pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic [DATA_W-1:0]   o_if_rdata,
  output logic                o_if_done,
  input  logic                i_mem_req,
  input  logic                i_mem_wen,
  input  logic [ADDR_W-1:0]   i_mem_addr,
  input  logic [DATA_W-1:0]   i_mem_wdata,
  input  logic [DATA_W/8-1:0] i_mem_mask,
  output logic [DATA_W-1:0]   o_mem_rdata,
  output logic                o_mem_done,
  output logic                o_port_valid,
  input  logic                i_port_ready,
  output logic [ADDR_W-1:0]   o_port_addr,
  output logic [DATA_W-1:0]   o_port_wdata,
  output logic [DATA_W/8-1:0] o_port_mask,
  output logic                o_port_wen,
  input  logic                i_port_rvalid,
  input  logic [DATA_W-1:0]   i_port_rdata,
  output logic                o_stall_if,
  output logic                o_stall_mem,
  output logic                o_wb_bubble,
`ifdef MEM_ARB_STATS_EN
  input  logic                i_stats_clr,
  output logic [STAT_W-1:0]   o_if_stall_cycles,
  output logic [STAT_W-1:0]   o_mem_stall_cycles,
`endif
  output arb_state_t          o_dbg_state
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_t state_q, state_d;
  grant_t     grant_q, last_grant_q, grant_sel;
  logic       grant_go;
  logic       port_valid;

  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [MASK_W-1:0] req_mask_q;
  logic              req_wen_q;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
  logic              if_done_q, mem_done_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= STATE_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_go) state_d = REQ;
      REQ:     if (port_valid && i_port_ready) state_d = WAIT;
      WAIT:    if (i_port_rvalid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grants only happen in IDLE, so a requester still high during its own
  // done cycle (RESP) cannot be re-issued.
  always_comb begin
    grant_go   = 1'b0;
    grant_sel  = GRANT_IF;
    port_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_if_req || i_mem_req) begin
          grant_go = 1'b1;
          if (i_if_req && i_mem_req) begin
            grant_sel = (last_grant_q == GRANT_IF) ? GRANT_MEM : GRANT_IF;
          end else if (i_mem_req) begin
            grant_sel = GRANT_MEM;
          end else begin
            grant_sel = GRANT_IF;
          end
        end
      end
      REQ:     port_valid = 1'b1;
      default: port_valid = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      grant_q      <= LAST_GRANT_RST;
      last_grant_q <= LAST_GRANT_RST;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_mask_q   <= '0;
      req_wen_q    <= FLAG_RST;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_done_q    <= FLAG_RST;
      mem_done_q   <= FLAG_RST;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if (grant_go) begin
        grant_q      <= grant_sel;
        last_grant_q <= grant_sel;
        if (grant_sel == GRANT_MEM) begin
          req_addr_q  <= i_mem_addr;
          req_wdata_q <= i_mem_wdata;
          req_mask_q  <= i_mem_mask;
          req_wen_q   <= i_mem_wen;
        end else begin
          req_addr_q  <= i_if_addr;
          req_wdata_q <= '0;
          req_mask_q  <= '1;
          req_wen_q   <= 1'b0;
        end
      end
      // Done flags rise on entry to RESP, so they are high for exactly that cycle.
      if ((state_q == WAIT) && i_port_rvalid) begin
        if (grant_q == GRANT_IF) begin
          if_rdata_q <= i_port_rdata;
          if_done_q  <= 1'b1;
        end else begin
          if (!req_wen_q) mem_rdata_q <= i_port_rdata;
          mem_done_q <= 1'b1;
        end
      end
    end
  end

  assign o_port_valid = port_valid;
  assign o_port_addr  = req_addr_q;
  assign o_port_wdata = req_wdata_q;
  assign o_port_mask  = req_mask_q;
  assign o_port_wen   = req_wen_q;
  assign o_if_rdata   = if_rdata_q;
  assign o_mem_rdata  = mem_rdata_q;
  assign o_if_done    = if_done_q;
  assign o_mem_done   = mem_done_q;
  assign o_stall_if   = i_if_req & ~if_done_q;
  assign o_stall_mem  = i_mem_req & ~mem_done_q;
  assign o_wb_bubble  = o_stall_mem;
  assign o_dbg_state  = state_q;

`ifdef MEM_ARB_STATS_EN
  sat_counter #(.WIDTH(STAT_W)) u_if_stall_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (o_stall_if),
    .i_clr   (i_stats_clr),
    .o_count (o_if_stall_cycles)
  );

  sat_counter #(.WIDTH(STAT_W)) u_mem_stall_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (o_stall_mem),
    .i_clr   (i_stats_clr),
    .o_count (o_mem_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; stats checks apply when MEM_ARB_STATS_EN is defined.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_if_req = 1'b0;
  logic [ADDR_W-1:0] i_if_addr = '0;
  logic [DATA_W-1:0] o_if_rdata;
  logic              o_if_done;
  logic              i_mem_req = 1'b0;
  logic              i_mem_wen = 1'b0;
  logic [ADDR_W-1:0] i_mem_addr = '0;
  logic [DATA_W-1:0] i_mem_wdata = '0;
  logic [MASK_W-1:0] i_mem_mask = '0;
  logic [DATA_W-1:0] o_mem_rdata;
  logic              o_mem_done;
  logic              o_port_valid;
  logic              i_port_ready = 1'b0;
  logic [ADDR_W-1:0] o_port_addr;
  logic [DATA_W-1:0] o_port_wdata;
  logic [MASK_W-1:0] o_port_mask;
  logic              o_port_wen;
  logic              i_port_rvalid = 1'b0;
  logic [DATA_W-1:0] i_port_rdata = '0;
  logic              o_stall_if;
  logic              o_stall_mem;
  logic              o_wb_bubble;
  arb_state_t        o_dbg_state;
`ifdef MEM_ARB_STATS_EN
  logic              i_stats_clr = 1'b0;
  logic [31:0]       o_if_stall_cycles;
  logic [31:0]       o_mem_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_if_req      (i_if_req),
    .i_if_addr     (i_if_addr),
    .o_if_rdata    (o_if_rdata),
    .o_if_done     (o_if_done),
    .i_mem_req     (i_mem_req),
    .i_mem_wen     (i_mem_wen),
    .i_mem_addr    (i_mem_addr),
    .i_mem_wdata   (i_mem_wdata),
    .i_mem_mask    (i_mem_mask),
    .o_mem_rdata   (o_mem_rdata),
    .o_mem_done    (o_mem_done),
    .o_port_valid  (o_port_valid),
    .i_port_ready  (i_port_ready),
    .o_port_addr   (o_port_addr),
    .o_port_wdata  (o_port_wdata),
    .o_port_mask   (o_port_mask),
    .o_port_wen    (o_port_wen),
    .i_port_rvalid (i_port_rvalid),
    .i_port_rdata  (i_port_rdata),
    .o_stall_if    (o_stall_if),
    .o_stall_mem   (o_stall_mem),
    .o_wb_bubble   (o_wb_bubble),
`ifdef MEM_ARB_STATS_EN
    .i_stats_clr        (i_stats_clr),
    .o_if_stall_cycles  (o_if_stall_cycles),
    .o_mem_stall_cycles (o_mem_stall_cycles),
`endif
    .o_dbg_state   (o_dbg_state)
  );

  // Clock / reset
  always #10 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic do_reset();
    i_rst = 1'b1;
    i_if_req = 1'b0;
    i_mem_req = 1'b0;
    i_port_ready = 1'b0;
    i_port_rvalid = 1'b0;
    step();
    step();
    i_rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!o_port_valid && n < 12) begin
      step();
      n++;
    end
    chk(tag, o_port_valid, 1);
  endtask

  // Called in the first REQ cycle; returns in the RESP cycle.
  task automatic serve(input int rdy_wait, input logic [DATA_W-1:0] rd);
    i_port_ready = 1'b0;
    for (int k = 0; k < rdy_wait; k++) step();
    i_port_ready = 1'b1;
    step();
    i_port_ready  = 1'b0;
    i_port_rvalid = 1'b1;
    i_port_rdata  = rd;
    step();
    i_port_rvalid = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_state", o_dbg_state, IDLE);
    chk("rst_port_valid", o_port_valid, 0);
    chk("rst_if_done", o_if_done, 0);
    chk("rst_mem_done", o_mem_done, 0);
    chk("rst_if_rdata", o_if_rdata, 0);
    chk("rst_mem_rdata", o_mem_rdata, 0);
    chk("rst_port_addr", o_port_addr, 0);
    chk("rst_port_mask", o_port_mask, 0);
    chk("rst_stall_if", o_stall_if, 0);
    chk("rst_bubble", o_wb_bubble, 0);
    do_reset();

    // Lone fetch, minimum latency: done in cycle 3
    i_if_req = 1'b1;
    i_if_addr = 32'h100;
    #1;
    chk("f_c0_stall_if", o_stall_if, 1);
    chk("f_c0_valid", o_port_valid, 0);
    step();
    chk("f_c1_valid", o_port_valid, 1);
    chk("f_c1_addr", o_port_addr, 32'h100);
    chk("f_c1_wen", o_port_wen, 0);
    chk("f_c1_mask", o_port_mask, 4'hF);
    chk("f_c1_stall_if", o_stall_if, 1);
    i_port_ready = 1'b1;
    step();
    chk("f_c2_state", o_dbg_state, WAIT);
    chk("f_c2_valid", o_port_valid, 0);
    chk("f_c2_stall_if", o_stall_if, 1);
    chk("f_c2_done", o_if_done, 0);
    i_port_ready = 1'b0;
    i_port_rvalid = 1'b1;
    i_port_rdata = 32'h00500093;
    step();
    i_port_rvalid = 1'b0;
    chk("f_c3_done", o_if_done, 1);
    chk("f_c3_rdata", o_if_rdata, 32'h00500093);
    chk("f_c3_stall_if", o_stall_if, 0);
    chk("f_c3_mem_done", o_mem_done, 0);
    i_if_req = 1'b0;
    step();
    chk("f_c4_done", o_if_done, 0);
    chk("f_c4_rdata_hold", o_if_rdata, 32'h00500093);
    chk("f_c4_state", o_dbg_state, IDLE);

    // Simultaneous fetch and read from reset: data first
    do_reset();
    i_if_req = 1'b1;
    i_if_addr = 32'h200;
    i_mem_req = 1'b1;
    i_mem_wen = 1'b0;
    i_mem_addr = 32'h3000;
    i_mem_wdata = 32'h55;
    i_mem_mask = 4'hF;
    #1;
    chk("tie_c0_bubble", o_wb_bubble, 1);
    step();
    chk("tie_addr_mem", o_port_addr, 32'h3000);
    chk("tie_bubble_req", o_wb_bubble, 1);
    serve(0, 32'hCAFEF00D);
    chk("tie_mem_done", o_mem_done, 1);
    chk("tie_mem_rdata", o_mem_rdata, 32'hCAFEF00D);
    chk("tie_bubble_done", o_wb_bubble, 0);
    chk("tie_if_done_no", o_if_done, 0);
    chk("tie_stall_if", o_stall_if, 1);
    i_mem_req = 1'b0;
    step();
    chk("tie_idle_state", o_dbg_state, IDLE);
    chk("tie_idle_valid", o_port_valid, 0);
    step();
    chk("tie_if_valid", o_port_valid, 1);
    chk("tie_if_addr", o_port_addr, 32'h200);
    chk("tie_if_wdata", o_port_wdata, 0);
    chk("tie_if_mask", o_port_mask, 4'hF);
    serve(0, 32'h13);
    chk("tie_if_done", o_if_done, 1);
    chk("tie_if_rdata", o_if_rdata, 32'h13);
    chk("tie_mem_rdata_hold", o_mem_rdata, 32'hCAFEF00D);
    i_if_req = 1'b0;
    step();

    // Store with ready held low for 3 cycles
    i_mem_req = 1'b1;
    i_mem_wen = 1'b1;
    i_mem_addr = 32'h2000;
    i_mem_wdata = 32'hBEEF;
    i_mem_mask = 4'b0011;
    #1;
    chk("st_c0_bubble", o_wb_bubble, 1);
    step();
    for (int k = 1; k <= 3; k++) begin
      chk("st_hold_valid", o_port_valid, 1);
      chk("st_hold_addr", o_port_addr, 32'h2000);
      chk("st_hold_wen", o_port_wen, 1);
      chk("st_hold_mask", o_port_mask, 4'b0011);
      chk("st_hold_wdata", o_port_wdata, 32'hBEEF);
      step();
    end
    chk("st_c4_valid", o_port_valid, 1);
    i_port_ready = 1'b1;
    step();
    i_port_ready = 1'b0;
    chk("st_c5_valid", o_port_valid, 0);
    chk("st_c5_done", o_mem_done, 0);
    i_port_rvalid = 1'b1;
    i_port_rdata = 32'hFFFF0000;
    step();
    i_port_rvalid = 1'b0;
    chk("st_c6_done", o_mem_done, 1);
    chk("st_c6_bubble", o_wb_bubble, 0);
    i_mem_req = 1'b0;
    i_mem_wen = 1'b0;
    step();
    chk("st_c7_done", o_mem_done, 0);

    // Both continuously pending: MEM, IF, MEM, IF, MEM, IF
    do_reset();
    i_if_req = 1'b1;
    i_if_addr = 32'h400;
    i_mem_req = 1'b1;
    i_mem_wen = 1'b0;
    i_mem_addr = 32'h5000;
    i_mem_mask = 4'hF;
    for (int i = 0; i < 6; i++) begin
      wait_valid("alt_valid");
      chk("alt_addr", o_port_addr, (i % 2 == 0) ? 32'h5000 : 32'h400);
      serve(0, 32'h1000 + i);
      chk("alt_mem_done", o_mem_done, (i % 2 == 0) ? 1 : 0);
      chk("alt_if_done", o_if_done, (i % 2 == 0) ? 0 : 1);
      if (i % 2 == 0) chk("alt_mem_rdata", o_mem_rdata, 32'h1000 + i);
      else            chk("alt_if_rdata", o_if_rdata, 32'h1000 + i);
    end
    i_if_req = 1'b0;
    i_mem_req = 1'b0;
    step();
    step();

    // Reset in WAIT, late response ignored
    i_if_req = 1'b1;
    i_if_addr = 32'h600;
    step();
    i_port_ready = 1'b1;
    step();
    i_port_ready = 1'b0;
    chk("rw_state_wait", o_dbg_state, WAIT);
    i_rst = 1'b1;
    #1;
    chk("rw_async_state", o_dbg_state, IDLE);
    chk("rw_async_valid", o_port_valid, 0);
    i_if_req = 1'b0;
    step();
    i_rst = 1'b0;
    i_port_rvalid = 1'b1;
    i_port_rdata = 32'hDEAD;
    step();
    i_port_rvalid = 1'b0;
    chk("rw_if_done", o_if_done, 0);
    chk("rw_mem_done", o_mem_done, 0);
    chk("rw_if_rdata", o_if_rdata, 0);
    chk("rw_mem_rdata", o_mem_rdata, 0);
    chk("rw_port_addr", o_port_addr, 0);
    chk("rw_port_valid", o_port_valid, 0);
    chk("rw_stall_if", o_stall_if, 0);
    step();
    chk("rw_if_done2", o_if_done, 0);
    i_mem_req = 1'b1;
    i_mem_addr = 32'h700;
    #1;
    wait_valid("rw_next_valid");
    chk("rw_next_addr", o_port_addr, 32'h700);
    serve(1, 32'h77);
    chk("rw_next_done", o_mem_done, 1);
    chk("rw_next_rdata", o_mem_rdata, 32'h77);
    i_mem_req = 1'b0;
    step();

`ifdef MEM_ARB_STATS_EN
    // 5-cycle data stall, then synchronous clear
    i_stats_clr = 1'b1;
    step();
    i_stats_clr = 1'b0;
    chk("st_cnt_clr0", o_mem_stall_cycles, 0);
    i_mem_req = 1'b1;
    i_mem_addr = 32'h800;
    step();
    serve(2, 32'h88);
    chk("st_cnt_done", o_mem_done, 1);
    chk("st_cnt_mem5", o_mem_stall_cycles, 5);
    chk("st_cnt_if0", o_if_stall_cycles, 0);
    i_mem_req = 1'b0;
    step();
    chk("st_cnt_mem_hold", o_mem_stall_cycles, 5);
    i_stats_clr = 1'b1;
    step();
    i_stats_clr = 1'b0;
    chk("st_cnt_mem_clr", o_mem_stall_cycles, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer that shares one single-ported, variable-latency memory between instruction fetch (IF) and the data access of the MEM stage. It owns the memory handshake, serialises requests, returns read data, and produces stall and bubble controls for the pipeline registers. When the MEM stage waits, its outputs freeze IF/ID, ID/EX and EX/MEM and insert an invalid entry into MEM/WB.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width. The mask is `DATA_W/8` bits.

Ports:
- `i_clk` input 1: clock.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_if_req` input 1: fetch request. Held until `o_if_done`.
- `i_if_addr` input ADDR_W: fetch address. Stable while `i_if_req` is high.
- `o_if_rdata` output DATA_W: fetched word. Valid when `o_if_done` is high.
- `o_if_done` output 1: one-cycle completion pulse for fetch.
- `i_mem_req` input 1: data request (`dmem_ren` | `dmem_wen`). Held until `o_mem_done`.
- `i_mem_wen` input 1: 1 = write, 0 = read.
- `i_mem_addr` input ADDR_W: data address.
- `i_mem_wdata` input DATA_W: write data.
- `i_mem_mask` input DATA_W/8: byte mask.
- `o_mem_rdata` output DATA_W: load data. Valid when `o_mem_done` is high.
- `o_mem_done` output 1: one-cycle completion pulse for the data access.
- `o_port_valid` output 1: request to memory.
- `i_port_ready` input 1: memory accepts the request.
- `o_port_addr`, `o_port_wdata`, `o_port_mask`, `o_port_wen`: outputs, registered request fields.
- `i_port_rvalid` input 1: response or write acknowledge.
- `i_port_rdata` input DATA_W: response data.
- `o_stall_if` output 1: `i_if_req & ~o_if_done`.
- `o_stall_mem` output 1: `i_mem_req & ~o_mem_done`. Freezes upstream registers.
- `o_wb_bubble` output 1: equals `o_stall_mem`. Forces the MEM/WB `valid` input to 0.

## Operation
- The state machine has four states:
  - IDLE → REQ when any request is pending.
  - REQ → WAIT on `o_port_valid & i_port_ready`.
  - WAIT → RESP on `i_port_rvalid`.
  - RESP → IDLE unconditionally.
- Grant in IDLE:
  - Only one request pending: that request wins.
  - Both pending: the requester not named by `last_grant` wins.
  - `last_grant` is updated on every grant and resets to IF, so data wins the first tie.
- On grant, the winning fields are latched into request registers, which drive all `o_port_*` outputs. Fetch latches `wen`=0, `mask`=all ones and `wdata`=0.
- `o_port_valid` is 1 only in REQ.
- In WAIT, `i_port_rdata` is captured into the granted side's rdata register when `i_port_rvalid` is high. Writes also wait for `i_port_rvalid`, and their rdata is don't-care.
- In RESP, exactly one done pulse is asserted, for the granted side.
- RESP never grants, so a request still held high during its own done cycle is not re-issued.
- Protocol errors: `i_port_rvalid` outside WAIT is ignored. `i_port_ready` outside REQ is ignored.
- Only one transaction is outstanding at any time.

## Timing
- Reset value of every output is 0, including the rdata registers. The state machine resets to IDLE.
- Asserting `i_rst` mid-transaction returns the block to IDLE immediately and drops `o_port_valid`. Late responses are ignored.
- Minimum latency: request seen in cycle 0 (IDLE), `o_port_valid` in cycle 1, done in cycle 3 when memory has ready=1 and rvalid in the earliest cycle.
- Each cycle of ready=0 or of rvalid delay adds one cycle.
- A new grant is possible in the cycle after RESP, i.e. a 4-cycle minimum issue interval.
- `o_if_rdata` and `o_mem_rdata` hold their last value until overwritten.
- Stall and bubble outputs are combinational from the request inputs and the registered done flags. Done flags are registered.

## Configuration
- `MEM_ARB_STATS_EN` defined: adds two 32-bit saturating counters.
  - `o_if_stall_cycles` counts cycles with `o_stall_if` = 1.
  - `o_mem_stall_cycles` counts cycles with `o_stall_mem` = 1.
  - Both reset to 0, stick at 0xFFFFFFFF, and clear synchronously on input `i_stats_clr`.
- `MEM_ARB_STATS_EN` undefined: those ports and the counters do not exist. Arbitration behaviour is identical.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, REQ, WAIT, RESP);
  - the grant enum (GRANT_IF, GRANT_MEM);
  - the reset-value constants.
- One sub-module, `sat_counter`, is parameterised by width, with `i_clk`, `i_rst`, `i_inc`, `i_clr` and `o_count`. It is instantiated twice under `MEM_ARB_STATS_EN`.

## Test plan
- Lone fetch, addr 0x100, memory ready=1 and rvalid next cycle with 0x00500093:
  - `o_if_done` pulses in cycle 3;
  - `o_if_rdata` = 0x00500093;
  - `o_stall_if` is high in cycles 0–2.
- Simultaneous fetch and read at reset:
  - data granted first;
  - fetch granted in the cycle after data's RESP;
  - `o_wb_bubble` is high until `o_mem_done`.
- Store to 0x2000 with mask 4'b0011, data 0xBEEF, ready held 0 for 3 cycles:
  - `o_port_valid` is held with fields stable for those cycles;
  - `o_port_wen`=1;
  - done arrives 3 cycles later than the minimum.
- Both requesters continuously pending for 6 transactions: grants alternate MEM, IF, MEM, IF, MEM, IF.
- `i_rst` asserted in WAIT, then rvalid arrives after reset is released:
  - no done pulse occurs;
  - all outputs read 0;
  - the next request is serviced normally.
- With `MEM_ARB_STATS_EN`, a 5-cycle data stall: `o_mem_stall_cycles` = 5, and it reads 0 after `i_stats_clr`.
